ps2_rx_frame: RTL and testbench
===============================

# ps2_rx_frame

Receiver for the two-wire serial keyboard link. It consumes the open-collector `ps2_clk` / `ps2_dat` pair produced by the device side, which idles high, changes data while the clock is high, and is sampled on the clock falling edge. It synchronises both wires into the system clock domain and deframes 11-bit frames: start 0, 8 data bits LSB first, odd parity, stop 1. Each good byte is presented on a valid/ready output port to the downstream keycode logic.

## Interface
- `SYNC_STAGES`, 2: flip-flop stages on each of `ps2_clk` and `ps2_dat`; minimum 2.
- `TIMEOUT_CYCLES`, 1000: system clocks without a falling edge before an in-progress frame is abandoned. Used only when the timeout is compiled in.
- `clk`  in  1  system clock, at least 8× the `ps2_clk` rate.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ps2_clk`  in  1  raw link clock; asynchronous; idle high.
- `ps2_dat`  in  1  raw link data; asynchronous; idle high.
- `rx_data`  out  8  received byte; stable while `rx_valid` is high.
- `rx_valid`  out  1  byte available.
- `rx_ready`  in  1  consumer accepts the byte.
- `parity_err`  out  1  one-cycle pulse: frame discarded because parity was even.
- `frame_err`  out  1  one-cycle pulse: frame discarded because of a bad stop bit or a timeout.
- `overrun`  out  1  one-cycle pulse: a good frame was dropped because the output was still full.

## Operation
- Synchroniser chains reset to 1, so reset release never creates a false edge.
- `fall` = previous synchronised `ps2_clk` high and current synchronised `ps2_clk` low. All frame state advances only on cycles where `fall` is high. Data is taken from the synchronised `ps2_dat` in that same cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall` with data 0, clear the 3-bit bit counter and go to DATA. On `fall` with data 1, stay in IDLE and raise no flag.
  - DATA: on `fall`, shift the bit into the shift register MSB and shift right, so LSB-first order lands correctly. Increment the counter. After the 8th bit, go to PARITY.
  - PARITY: on `fall`, latch `par_ok` = XOR of the 8 data bits and the parity bit equals 1. Go to STOP.
  - STOP: on `fall`, always return to IDLE, then:
    - stop bit 0 → pulse `frame_err`;
    - stop bit 1 and not `par_ok` → pulse `parity_err`;
    - stop bit 0 and not `par_ok` → pulse both flags;
    - stop bit 1 and `par_ok` → deliver the byte.
- Delivery:
  - If the output is empty, or `rx_valid` and `rx_ready` are both high that cycle, load `rx_data` and set `rx_valid`.
  - Otherwise pulse `overrun`, drop the new byte, and keep the old byte.
- Handshake: a byte is consumed on any cycle where `rx_valid` and `rx_ready` are both high. `rx_valid` then clears unless a new byte loads in the same cycle.
- Reset (asynchronous, any time, including mid-frame):
  - FSM to IDLE; counter and shift register to 0.
  - `rx_data` = 0x00; `rx_valid`, `parity_err`, `frame_err` and `overrun` all 0.

## Timing
- The edge-detect register sees a `ps2_clk` low level `SYNC_STAGES` clocks after it is first sampled. `fall` is high on the following cycle.
- Latency: `rx_valid` rises on the clock edge after the cycle in which the stop-bit `fall` is high. That is `SYNC_STAGES`+1 clocks after `ps2_clk` is first sampled low at the stop bit.
- Error and overrun flags pulse in that same cycle and last exactly one clock.
- Back-to-back frames and `rx_ready` held high: no frame is lost. Bit time is at least 8 clocks, so a byte loaded on one stop bit is always consumable before the next.
- Output is full on delivery and `rx_ready` is high that cycle: consume the old byte and load the new one, with no overrun.

## Configuration
- `PS2_RX_TIMEOUT_EN` defined:
  - A counter clears on each `fall` and increments every clock while the FSM is outside IDLE.
  - On reaching `TIMEOUT_CYCLES`: FSM to IDLE, pulse `frame_err`, deliver nothing.
  - In IDLE the counter is held at 0.
- `PS2_RX_TIMEOUT_EN` undefined: no counter; the FSM waits indefinitely for the next `fall`.

## Test plan
- Bench conditions for all scenarios: `clk` 1 MHz; `ps2_clk` low 40 µs, high 40 µs; data set 20 µs before the falling edge.
- Bytes 0x00–0x0F, correctly framed, `rx_ready`=1 → sixteen one-cycle `rx_valid` pulses with `rx_data`=0x00..0x0F in order; no error or overrun pulses.
- 0xA5 sent with parity bit 0 (correct value is 1) → one `parity_err` pulse; no `rx_valid`. A following good 0x5A is received correctly.
- 0x3C sent with stop bit 0 → one `frame_err` pulse; no `rx_valid`.
- `rx_ready`=0, send 0x12 then 0x34 → `rx_valid` high with 0x12 throughout; one `overrun` pulse at the 0x34 stop bit. Raise `rx_ready` for one cycle → `rx_valid` falls; `rx_data` stays 0x12.
- `PS2_RX_TIMEOUT_EN` defined: send start bit plus 3 data bits, then hold both wires high for 2 ms → `frame_err` pulses 1000 clocks after the last `fall`. A following 0x55 is then received correctly.
- Assert `reset_n`=0 for 5 µs after the 4th data bit of 0x81, then send 0x81 again after 2 ms idle → all outputs are 0 during reset. The second 0x81 is delivered, with `PS2_RX_TIMEOUT_EN` defined.

Source files
------------

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: synchronises ps2_clk/ps2_dat, deframes 11-bit frames, and presents bytes on valid/ready.
// Optional frame timeout is compiled in with `define PS2_RX_TIMEOUT_EN.
//
// state    | meaning
// ---------+--------------------------------------------------
// S_IDLE   | waiting for a start bit (falling edge with data 0)
// S_DATA   | shifting in 8 data bits, LSB first
// S_PARITY | sampling the odd-parity bit
// S_STOP   | sampling the stop bit, then deliver or flag error
module ps2_rx_frame #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  generate
    if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("ps2_rx_frame: SYNC_STAGES must be >= 2 and TIMEOUT_CYCLES >= 1");
    end
  endgenerate

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   clk_cur, clk_prev, dat_cur;
  logic                   fall;
  logic [2:0]             bit_cnt, bit_cnt_nxt;
  logic [7:0]             shift_reg, shift_nxt;
  logic                   par_ok, par_ok_nxt;
  logic                   good, perr_nxt, ferr_nxt, timeout;
  logic                   take, load;

  // Chains reset high so reset release never looks like a falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_cur  <= 1'b1;
      clk_prev <= 1'b1;
      dat_cur  <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
      clk_cur  <= clk_sync[SYNC_STAGES-1];
      clk_prev <= clk_cur;
      dat_cur  <= dat_sync[SYNC_STAGES-1];
    end
  end

  assign fall = clk_prev & ~clk_cur;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    tmo_cnt <= '0;
    else if (state == S_IDLE || fall) tmo_cnt <= '0;
    else                             tmo_cnt <= TW'(tmo_cnt + 1'b1);
  end

  assign timeout = (state != S_IDLE) && !fall && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      bit_cnt   <= 3'd0;
      shift_reg <= 8'h00;
      par_ok    <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift_reg <= shift_nxt;
      par_ok    <= par_ok_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift_reg;
    par_ok_nxt  = par_ok;
    good        = 1'b0;
    perr_nxt    = 1'b0;
    ferr_nxt    = 1'b0;
    if (timeout) begin
      state_nxt = S_IDLE;
      ferr_nxt  = 1'b1;
    end else if (fall) begin
      case (state)
        S_IDLE: begin
          if (!dat_cur) begin
            bit_cnt_nxt = 3'd0;
            state_nxt   = S_DATA;
          end
        end
        S_DATA: begin
          shift_nxt   = {dat_cur, shift_reg[7:1]};
          bit_cnt_nxt = 3'(bit_cnt + 3'd1);
          if (bit_cnt == 3'd7) state_nxt = S_PARITY;
        end
        S_PARITY: begin
          par_ok_nxt = (^shift_reg) ^ dat_cur;
          state_nxt  = S_STOP;
        end
        S_STOP: begin
          state_nxt = S_IDLE;
          ferr_nxt  = ~dat_cur;
          perr_nxt  = ~par_ok;
          good      = dat_cur & par_ok;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // A full output may still accept a new byte if the old one is consumed this cycle.
  assign take = rx_valid & rx_ready;
  assign load = good & (~rx_valid | take);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (load) begin
        rx_data  <= shift_reg;
        rx_valid <= 1'b1;
      end else if (take) begin
        rx_valid <= 1'b0;
      end
      parity_err <= perr_nxt;
      frame_err  <= ferr_nxt;
      overrun    <= good & ~load;
    end
  end

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Directed bench for ps2_rx_frame: good bytes, parity/stop errors, overrun, mid-frame reset,
// and the frame timeout when PS2_RX_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_ps2_rx_frame;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       ps2_clk, ps2_dat;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic       parity_err, frame_err, overrun;

  int errors = 0;
  int checks = 0;

  logic [7:0] got_q[$];
  int  n_vrise = 0, n_vcyc = 0, n_perr = 0, n_ferr = 0, n_ovr = 0;
  logic prev_valid = 1'b0;
  time t_fall = 0, t_vrise = 0, t_ferr = 0;
  int  exp_ferr;

  ps2_rx_frame #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(1000)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #500 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (rx_valid) n_vcyc++;
    if (rx_valid && !prev_valid) begin
      n_vrise++;
      t_vrise = $time;
    end
    prev_valid = rx_valid;
    if (parity_err) n_perr++;
    if (frame_err) begin
      n_ferr++;
      t_ferr = $time;
    end
    if (overrun) n_ovr++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // 80 us bit period: data set 20 us before the fall, clock low 40 us, high 40 us.
  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_bit,
                            input int nbits);
    logic [10:0] f;
    f = {stop_bit, ~(^d) ^ par_flip, d, 1'b0};
    for (int b = 0; b < nbits; b++) begin
      ps2_dat = f[b];
      #20000;
      ps2_clk = 1'b0;
      t_fall  = $time;
      #40000;
      ps2_clk = 1'b1;
      #20000;
    end
    ps2_dat = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, rx_valid, 0);
    chk({tag, "_data"}, rx_data, 8'h00);
    chk({tag, "_perr"}, parity_err, 0);
    chk({tag, "_ferr"}, frame_err, 0);
    chk({tag, "_ovr"}, overrun, 0);
  endtask

  initial begin
    reset_n  = 1'b0;
    ps2_clk  = 1'b1;
    ps2_dat  = 1'b1;
    rx_ready = 1'b1;
`ifdef PS2_RX_TIMEOUT_EN
    exp_ferr = 2;
`else
    exp_ferr = 1;
`endif
    repeat (3) @(negedge clk);
    chk_reset_outputs("init_rst");
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_valid", rx_valid, 0);

    // sixteen good bytes with the consumer always ready
    for (int i = 0; i < 16; i++) begin
      send_frame(8'(i), 1'b0, 1'b1, 11);
      if (i == 0) chk("latency_ns", 32'(t_vrise - t_fall), 4000);
    end
    chk("seq_count", got_q.size(), 16);
    for (int i = 0; i < 16; i++) chk($sformatf("seq_byte%0d", i), got_q[i], i);
    chk("seq_vrise", n_vrise, 16);
    chk("seq_vcyc", n_vcyc, 16);
    chk("seq_perr", n_perr, 0);
    chk("seq_ferr", n_ferr, 0);
    chk("seq_ovr", n_ovr, 0);

    // bad parity on 0xA5, then a good 0x5A
    send_frame(8'hA5, 1'b1, 1'b1, 11);
    chk("par_perr", n_perr, 1);
    chk("par_novalid", n_vrise, 16);
    send_frame(8'h5A, 1'b0, 1'b1, 11);
    chk("par_next_count", got_q.size(), 17);
    chk("par_next_byte", got_q[16], 8'h5A);

    // bad stop bit on 0x3C
    send_frame(8'h3C, 1'b0, 1'b0, 11);
    chk("stop_ferr", n_ferr, 1);
    chk("stop_perr", n_perr, 1);
    chk("stop_novalid", n_vrise, 17);

    // overrun with the consumer stalled
    rx_ready = 1'b0;
    send_frame(8'h12, 1'b0, 1'b1, 11);
    chk("ovr_valid1", rx_valid, 1);
    chk("ovr_data1", rx_data, 8'h12);
    send_frame(8'h34, 1'b0, 1'b1, 11);
    chk("ovr_valid2", rx_valid, 1);
    chk("ovr_data2", rx_data, 8'h12);
    chk("ovr_pulse", n_ovr, 1);
    chk("ovr_vrise", n_vrise, 18);
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    chk("ovr_pop_valid", rx_valid, 0);
    chk("ovr_pop_data", rx_data, 8'h12);
    chk("ovr_pop_byte", got_q[17], 8'h12);
    rx_ready = 1'b1;

`ifdef PS2_RX_TIMEOUT_EN
    // abandoned frame: start + 3 data bits, then idle
    send_frame(8'h55, 1'b0, 1'b1, 4);
    #2000000;
    chk("tmo_ferr", n_ferr, 2);
    chk("tmo_delay_cyc", 32'((t_ferr - t_fall) / 1000), 1004);
    send_frame(8'h55, 1'b0, 1'b1, 11);
    chk("tmo_next_count", got_q.size(), 19);
    chk("tmo_next_byte", got_q[18], 8'h55);
`endif

    // reset in the middle of 0x81 (after its 4th data bit)
    send_frame(8'h81, 1'b0, 1'b1, 5);
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("mid_rst");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #2000000;
    send_frame(8'h81, 1'b0, 1'b1, 11);
    chk("rst_next_count", got_q.size(), exp_ferr == 2 ? 20 : 19);
    chk("rst_next_byte", got_q[got_q.size() - 1], 8'h81);
    chk("rst_ferr", n_ferr, exp_ferr);
    chk("rst_perr", n_perr, 1);
    chk("rst_ovr", n_ovr, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
